// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the IF/MEM unified memory arbiter.
//   arb_state_e : IDLE / BUSY_I (fetch) / BUSY_D (data) / BUSY_X (flushed fetch)
//   arb_owner_e : owning pipeline stage of a transaction
//   STARVE_LIMIT_DEF, TIMEOUT_DEF : parameter defaults for the top
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    BUSY_X = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 15;

endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port, variable-latency memory between
// the IF (fetch) and MEM (load/store) stages, one transaction in flight.
//   clk, rst        : clock, synchronous active-high reset
//   if_*            : fetch request / flush / instruction return
//   d_*             : load/store request / load data return
//   mem_*           : registered memory request, ack and read data
//   stall_if/_mem   : combinational per-stage stalls to hazard control
//   bus_err         : sticky memory-timeout flag
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  arb_state_e          r_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_be;
  logic [SC_W-1:0]     r_starve;
  logic [WC_W-1:0]     r_wait;
  logic                r_bus_err;

  logic w_grant_d, w_grant_i, w_busy, w_tmo, w_done;

  // Data wins unless the pending fetch has already sat through STARVE_LIMIT
  // data grants; a fetch being flushed this cycle is never granted.
  assign w_grant_d = d_req && (!if_req || (r_starve < SC_W'(STARVE_LIMIT)));
  assign w_grant_i = !w_grant_d && if_req && !if_flush;

  // r_wait counts busy cycles already spent without ack, so the abort lands
  // in the TIMEOUT-th busy cycle. A real ack in that cycle takes precedence.
  assign w_busy = (r_state != IDLE);
  assign w_tmo  = w_busy && !mem_ack && (r_wait == WC_W'(TIMEOUT - 1));
  assign w_done = w_busy && (mem_ack || w_tmo);

  // Completion is combinational in the ack cycle; a flush in that same cycle
  // still kills the fetch return. Aborts return zero data.
  assign if_rvalid = !rst && (r_state == BUSY_I) && w_done && !if_flush;
  assign if_rdata  = (if_rvalid && mem_ack) ? mem_rdata : '0;
  assign d_rvalid  = !rst && (r_state == BUSY_D) && w_done;
  assign d_rdata   = (d_rvalid && mem_ack) ? mem_rdata : '0;

  assign stall_if  = if_req && !if_rvalid;
  assign stall_mem = d_req && !d_rvalid;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_starve    <= '0;
      r_wait      <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait <= '0;
          if (!if_req) r_starve <= '0;
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_be    <= d_be;
            // A grant with if_req high implies r_starve < limit, so no overflow.
            if (if_req) r_starve <= r_starve + SC_W'(1);
          end else if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
            r_starve    <= '0;
          end
        end
        default: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            if (w_tmo) r_bus_err <= 1'b1;
          end else if ((r_state == BUSY_I) && if_flush) begin
            // The access keeps running to completion; only the return is dropped.
            r_state <= BUSY_X;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WC_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_be;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          stall_if, stall_mem, bus_err;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  typedef struct {bit st; logic [31:0] d;} exp_t;

  exp_t        dq[$];
  logic [31:0] fq[$];
  byte         grants[$];
  logic [31:0] dev_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  int          n_cmp = 0, n_err = 0;
  int          rsp_mode = 0, fix_lat = 0;
  bit          man_ack = 1'b0;
  logic        prev_req = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AF00F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a[31:2]) ? dev_mem[a[31:2]] : init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Memory device: random or fixed ack latency, never-ack, or manual ack.
  initial begin
    int cnt, cur_lat;
    cnt = 0; cur_lat = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (rsp_mode == 3) mem_ack = man_ack;
      else if (!mem_req) begin
        cnt = 0;
        cur_lat = (rsp_mode == 0) ? $urandom_range(0, 4) : fix_lat;
      end else if (rsp_mode != 2 && cnt >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = dev_read(mem_addr);
        if (mem_we) dev_mem[mem_addr[31:2]] = merge(dev_read(mem_addr), mem_wdata, mem_be);
        cnt = 0;
      end else cnt++;
    end
  end

  // Scoreboard monitor: pops the expected response whenever a stage sees rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (if_rvalid === 1'b1) begin
      if (fq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL if_rvalid_unexpected: got rvalid rdata %h, expected no return", if_rdata);
      end else chk("if_rdata", if_rdata, fq.pop_front());
    end
    if (d_rvalid === 1'b1) begin
      if (dq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL d_rvalid_unexpected: got rvalid rdata %h, expected no return", d_rdata);
      end else begin
        e = dq.pop_front();
        if (!e.st) chk("d_rdata", d_rdata, e.d);
      end
    end
    if (mem_req && !prev_req) grants.push_back((mem_addr >= 32'h1000) ? "I" : "D");
    prev_req = mem_req;
  end

  task automatic do_fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    fq.push_back(ref_read(a));
  endtask

  task automatic issue_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    if (we) begin
      ref_mem[a[31:2]] = merge(ref_read(a), wd, be);
      dq.push_back('{1'b1, 32'h0});
    end else dq.push_back('{1'b0, ref_read(a)});
  endtask

  // Waits for the stage's rvalid; cyc counts mem_req-high cycles incl. the last.
  task automatic wait_rv(input bit is_d, output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_req) cyc++;
      if (is_d ? d_rvalid : if_rvalid) return;
    end
    n_cmp++; n_err++;
    $display("FAIL %s_wait: got no rvalid, expected one within 200 cycles", is_d ? "d" : "if");
  endtask

  task automatic set_rsp(input int mode, input int lat);
    @(negedge clk); rsp_mode = mode; fix_lat = lat;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, got;
    string exp_g;
    rst = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    rsp_mode = 3; man_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with a stray ack present in IDLE
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);   chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0); chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0); chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0); chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    man_ack = 1'b0;

    // 1. single fetch, ack one cycle after mem_req
    set_rsp(1, 1);
    dev_mem[0] = 32'h0062A223; ref_mem[0] = 32'h0062A223;
    do_fetch(32'h0);
    @(negedge clk); chk1("t1_c0_req", mem_req, 1'b0); chk1("t1_c0_stall", stall_if, 1'b1);
    @(negedge clk); chk1("t1_c1_req", mem_req, 1'b1); chk1("t1_c1_we", mem_we, 1'b0);
    chk("t1_c1_be", 32'(mem_be), 32'hF); chk("t1_c1_addr", mem_addr, 32'h0);
    chk1("t1_c1_rvalid", if_rvalid, 1'b0);
    @(negedge clk); chk1("t1_c2_rvalid", if_rvalid, 1'b1); chk1("t1_c2_stall", stall_if, 1'b0);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk); chk1("t1_c3_req", mem_req, 1'b0); chk1("t1_c3_stall", stall_if, 1'b0);

    // 2. contention: store first, then fetch, then load back
    set_rsp(1, 2);
    do_fetch(32'h1000);
    issue_d(1'b1, 32'd204, 32'd123, 4'hF);
    @(negedge clk); chk1("t2_c0_req", mem_req, 1'b0);
    @(negedge clk); chk1("t2_st_we", mem_we, 1'b1); chk("t2_st_addr", mem_addr, 32'd204);
    chk("t2_st_wdata", mem_wdata, 32'd123);
    chk1("t2_stall_if", stall_if, 1'b1); chk1("t2_stall_mem", stall_mem, 1'b1);
    wait_rv(1'b1, c);
    @(posedge clk); #1 d_req = 0;
    @(negedge clk); chk1("t2_gap_req", mem_req, 1'b0);
    @(negedge clk); chk1("t2_if_req", mem_req, 1'b1); chk1("t2_if_we", mem_we, 1'b0);
    chk("t2_if_addr", mem_addr, 32'h1000);
    wait_rv(1'b0, c);
    @(posedge clk); #1 if_req = 0;
    issue_d(1'b0, 32'd204, 32'h0, 4'hF);
    wait_rv(1'b1, c);
    @(posedge clk); #1 d_req = 0;

    // 3. starvation: 6 back-to-back loads against a held fetch
    set_rsp(0, 0);
    grants.delete();
    fork
      begin
        int cf;
        do_fetch(32'h1100);
        wait_rv(1'b0, cf);
        @(posedge clk); #1 if_req = 0;
      end
      begin
        int cd;
        for (int i = 0; i < 6; i++) begin
          issue_d(1'b0, 32'(8 * i), 32'h0, 4'hF);
          wait_rv(1'b1, cd);
          @(posedge clk); #1;
        end
        d_req = 0;
      end
    join
    exp_g = "DDDDIDD";
    chk("t3_grant_count", grants.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < grants.size()) chk($sformatf("t3_grant_%0d", i), 32'(grants[i]), 32'(exp_g[i]));

    // 4. flush while fetch in flight
    set_rsp(1, 3);
    do_fetch(32'h1200);
    @(negedge clk); @(negedge clk); chk1("t4_busy_req", mem_req, 1'b1);
    @(posedge clk); #1 if_flush = 1; fq.delete(); do_fetch(32'h1300);
    @(posedge clk); #1 if_flush = 0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (mem_ack) got = 1;
    end
    chk("t4_ack_seen", got, 32'd1);
    chk1("t4_no_rvalid", if_rvalid, 1'b0);
    @(negedge clk); chk1("t4_idle_req", mem_req, 1'b0);
    @(negedge clk); chk1("t4_regrant_req", mem_req, 1'b1); chk("t4_regrant_addr", mem_addr, 32'h1300);
    wait_rv(1'b0, c);
    @(posedge clk); #1 if_req = 0;

    // Randomised traffic: concurrent fetch (with flushes) and load/store agents
    set_rsp(0, 0);
    fork
      begin
        logic [31:0] a;
        int done;
        for (int n = 0; n < 50; n++) begin
          a = 32'h1000 + 4 * $urandom_range(0, 255);
          do_fetch(a);
          done = 0;
          for (int k = 0; k < 200 && done == 0; k++) begin
            @(negedge clk);
            if (if_rvalid) done = 1;
            else begin
              @(posedge clk); #1 if_flush = 0;
              if ($urandom_range(0, 11) == 0) begin
                if_flush = 1; fq.delete();
                a = 32'h1000 + 4 * $urandom_range(0, 255);
                do_fetch(a);
              end
            end
          end
          if (done == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_if_wait: got no rvalid, expected one within 200 cycles");
          end
          @(posedge clk); #1 if_flush = 0; if_req = 0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int cr;
        for (int n = 0; n < 70; n++) begin
          issue_d(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 63)), $urandom,
                  4'($urandom_range(1, 15)));
          wait_rv(1'b1, cr);
          @(posedge clk); #1 d_req = 0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    chk1("rnd_bus_err", bus_err, 1'b0);
    chk("rnd_dq_empty", dq.size(), 32'd0);
    chk("rnd_fq_empty", fq.size(), 32'd0);

    // 5. timeout on a load
    set_rsp(2, 0);
    issue_d(1'b0, 32'h40, 32'h0, 4'hF);
    void'(dq.pop_back()); dq.push_back('{1'b0, 32'h0});
    wait_rv(1'b1, c);
    chk("t5_cycles", c, TO);
    chk1("t5_rvalid", d_rvalid, 1'b1);
    @(posedge clk); #1 d_req = 0;
    @(negedge clk); chk1("t5_bus_err", bus_err, 1'b1); chk1("t5_req_drop", mem_req, 1'b0);
    rsp_mode = 0;
    @(posedge clk); #1;
    do_fetch(32'h1400);
    wait_rv(1'b0, c);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk); chk1("t5_bus_err_sticky", bus_err, 1'b1);

    // 6. reset while a load is in flight, ack arriving late
    set_rsp(2, 0);
    issue_d(1'b0, 32'h80, 32'h0, 4'hF);
    @(negedge clk); @(negedge clk); chk1("t6_busy_req", mem_req, 1'b1);
    rsp_mode = 3; man_ack = 1'b1;
    @(posedge clk); #1 rst = 1'b1; d_req = 0; dq.delete();
    @(negedge clk); chk1("t6_rst_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk1("t6_req", mem_req, 1'b0); chk1("t6_rvalid", d_rvalid, 1'b0);
    chk1("t6_bus_err", bus_err, 1'b0);
    @(negedge clk); chk1("t6_late_rvalid", d_rvalid, 1'b0); chk1("t6_late_req", mem_req, 1'b0);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV32I pipeline.
- Sequences one outstanding transaction at a time.
- Returns read data and completion to the owning stage, and drives per-stage stall signals to hazard control.
- Adds starvation protection for fetch and a memory-timeout error path.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width (byte enables = DATA_W/8)
STARVE_LIMIT, 4, consecutive data grants while a fetch is pending before fetch is forced
TIMEOUT, 15, cycles in a busy state without mem_ack before abort (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_rvalid or if_flush
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  branch/jump redirect; drops the current fetch
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  instruction word
d_req  in  1  load/store request, held until d_rvalid
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_rvalid  out  1  load data valid / store done
d_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  if_req && !if_rvalid
stall_mem  out  1  d_req && !d_rvalid
bus_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_req, mem_we, bus_err, if_rvalid and d_rvalid are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0. mem_be is 0.
  - Starvation and timeout counters are 0.
  - A mem_ack arriving during or after reset, while in IDLE, is ignored.
- States:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
  - BUSY_X: flushed fetch still in flight.
- IDLE arbitration (registered):
  - If d_req is set and (!if_req or starve_cnt < STARVE_LIMIT), go to BUSY_D.
  - Otherwise, if if_req && !if_flush, go to BUSY_I.
  - On the grant edge, latch address, we, wdata and be into the mem_* registers, and set mem_req=1.
  - For fetches: mem_we=0 and mem_be all ones.
- mem_* outputs:
  - Registered, and held stable while in a busy state.
  - mem_req drops at the edge that ends the ack cycle.
- Completion:
  - In BUSY_I with mem_ack: if_rvalid=1 and if_rdata=mem_rdata, combinationally in the ack cycle. Next state is IDLE.
  - BUSY_D is the same, using d_rvalid/d_rdata. For stores, d_rdata is don't-care.
- Latency:
  - Minimum is 2 cycles: request seen in cycle 0, mem_req in cycle 1, ack in cycle 1 gives rvalid in cycle 1.
  - A new request can be granted in the cycle after completion.
- Flush:
  - if_flush while in BUSY_I moves to BUSY_X. The memory access still completes, and if_rvalid is suppressed.
  - On ack in BUSY_X, go to IDLE with no rvalid.
  - if_flush in the ack cycle of BUSY_I suppresses if_rvalid.
- starve_cnt:
  - Increments on each BUSY_D grant while if_req is high, saturating at STARVE_LIMIT.
  - Clears on a BUSY_I grant or whenever if_req is low in IDLE.
- Timeout:
  - A wait counter clears on entry to each busy state.
  - When it reaches TIMEOUT without ack, the transaction completes with rdata=0 and rvalid for the owner (suppressed if BUSY_X).
  - bus_err is set and holds until rst. mem_req is dropped.
- Simultaneous if_req and d_req: data wins unless starvation is forced.
- Stall signals:
  - Purely combinational.
  - Both may be high at once; hazard control freezes the pipeline.

Decomposition:
- Shared package `mem_arb_pkg` contains:
  - the state enum {IDLE, BUSY_I, BUSY_D, BUSY_X};
  - the owner enum {OWN_IF, OWN_D};
  - default STARVE_LIMIT and TIMEOUT constants.
- No sub-module is natural. The block is a single FSM with two counters, kept flat.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x0, mem_ack one cycle after mem_req with rdata=0x0062A223 -> mem_req in cycle 1, if_rvalid=1 with if_rdata=0x0062A223 in the ack cycle, stall_if low in the next cycle.
2. Contention: if_req and d_req both high (store, d_addr=204, d_wdata=123, d_be=0xF), ack latency 2 -> the store is issued first with mem_we=1 and mem_addr=204, then the fetch; the follow-up load of 204 returns 123.
3. Starvation: d_req held high for 6 back-to-back loads with if_req high, STARVE_LIMIT=4 -> the 5th grant goes to fetch, then data resumes.
4. Flush: if_flush pulsed while in BUSY_I, ack after 3 cycles -> no if_rvalid; the next fetch of the new PC is granted in the cycle after the ack.
5. Timeout: mem_ack never asserted on a load -> after TIMEOUT=15 cycles, d_rvalid=1, d_rdata=0, bus_err=1 and sticky; the subsequent fetch proceeds normally.
6. Reset mid-transaction: rst=1 while in BUSY_D -> on the next edge mem_req=0 and state is IDLE; a late mem_ack produces no rvalid.
